// File: rtl/move_input_conditioner_if.sv
// Move command handshake between the input conditioner and the board-update block.
// The master presents move_valid/move_dir and the slave answers with move_ready.
interface move_input_conditioner_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_input_conditioner.sv
// Turns four raw push-buttons into single move commands: sync, debounce, edge, arbitrate, buffer.
// Optional auto-repeat of a held button is enabled by defining AUTO_REPEAT_EN.
//
// state   | meaning
// S_IDLE  | no command held, move_valid=0, move_ready ignored
// S_VALID | command presented on move_dir, waiting for move_ready
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            btn_u,
  input  logic                            btn_d,
  input  logic                            btn_l,
  input  logic                            btn_r,
  move_input_conditioner_if.master        mv,
  output logic                            overrun
);

  typedef enum logic {S_IDLE, S_VALID} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [3:0]       raw, sync1, sync2, stable, stable_q;
  logic [3:0]       press, synth, ev;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       win_dir;
  logic             multi;
  logic             valid_q;
  logic [1:0]       dir_q;

  function automatic logic [1:0] prio(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign raw = {btn_r, btn_l, btn_d, btn_u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only rising stable levels are moves; releases are silent.
  assign press = stable & ~stable_q;

`ifdef AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic            hold_vld;
  logic [1:0]      hold_dir;
  logic [RP_W-1:0] hold_cnt;
  logic            held_any;
  logic [1:0]      held_win;
  logic            repeat_hit;

  assign held_any   = |stable;
  assign held_win   = prio(stable);
  assign repeat_hit = hold_vld && held_any && (held_win == hold_dir) && (hold_cnt == '0);
  assign synth      = repeat_hit ? (4'b0001 << hold_dir) : 4'b0000;

  // Down-counter reloads on a new held winner; terminal count emits a synthetic press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_dir <= 2'd0;
      hold_cnt <= '0;
    end else if (!held_any) begin
      hold_vld <= 1'b0;
      hold_cnt <= '0;
    end else if (!hold_vld || (held_win != hold_dir)) begin
      hold_vld <= 1'b1;
      hold_dir <= held_win;
      hold_cnt <= RP_W'(REPEAT_DELAY - 1);
    end else if (hold_cnt == '0) begin
      hold_cnt <= RP_W'(REPEAT_PERIOD - 1);
    end else begin
      hold_cnt <= hold_cnt - RP_W'(1);
    end
  end
`else
  assign synth = 4'b0000;
`endif

  assign ev      = press | synth;
  assign win_dir = prio(ev);
  assign multi   = |(ev & (ev - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      dir_q   <= 2'd0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|ev) begin
            state   <= S_VALID;
            valid_q <= 1'b1;
            dir_q   <= win_dir;
            overrun <= multi;
          end
        end
        S_VALID: begin
          if (!mv.move_ready) begin
            overrun <= |ev;
          end else if (|ev) begin
            dir_q   <= win_dir;
            overrun <= multi;
          end else begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mv.move_valid = valid_q;
  assign mv.move_dir   = dir_q;

endmodule
